// File: rtl/bus_rr_sched_ctrl.sv
// Round-robin scheduler for the shared packet bus: grants one pending device,
// pops its head packet and pushes it to the decoded destination(s).
module bus_rr_sched_ctrl #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [pckg_sz-1:0]         D_push,
  output logic [drvrs-1:0]           push,
  output logic                       busy,
  output logic [7:0]                 grant_id,
  output logic [15:0]                pkt_cnt,
  output logic [15:0]                drop_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] POP   = 2'd1;
  localparam logic [1:0] ROUTE = 2'd2;
  localparam logic [1:0] PUSH  = 2'd3;

  localparam int unsigned     IW   = $clog2(drvrs);
  localparam logic [7:0]      DRV8 = 8'(drvrs);
  localparam logic [8:0]      DRV9 = 9'(drvrs);
  localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

  logic [1:0]         state, state_nxt;
  logic [7:0]         rr_ptr;
  logic [pckg_sz-1:0] cap, head;
  logic [drvrs-1:0]   mask, route_mask, grant_oh;
  logic [7:0]         dest, sel;
  logic [8:0]         idx;
  logic               found;

  // First pending device at or above rr_ptr, wrapping modulo drvrs.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      idx = {1'b0, rr_ptr} + 9'(i);
      if (idx >= DRV9) idx = idx - DRV9;
      if (!found && pndng[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[7:0];
      end
    end
  end

  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < drvrs; i++)
      if (grant_id == 8'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
  end

  assign grant_oh = ONE << grant_id;
  assign dest     = cap[pckg_sz-1 -: 8];

  always_comb begin
    if (dest == broadcast)  route_mask = ~grant_oh;
    else if (dest < DRV8)   route_mask = ONE << dest;
    else                    route_mask = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = POP;
      POP:     state_nxt = pndng[grant_id[IW-1:0]] ? ROUTE : IDLE;
      ROUTE:   state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      grant_id <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      rr_ptr   <= '0;
      cap      <= '0;
      mask     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      pop   <= '0;
      push  <= '0;
      case (state)
        IDLE: if (found) grant_id <= sel;
        POP: begin
          if (pndng[grant_id[IW-1:0]]) begin
            pop <= grant_oh;
            cap <= head;
          end
        end
        ROUTE: mask <= route_mask;
        PUSH: begin
          if (mask != '0) begin
            push    <= mask;
            D_push  <= cap;
            pkt_cnt <= pkt_cnt + 16'd1;
          end else if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
          rr_ptr <= (grant_id == DRV8 - 8'd1) ? '0 : grant_id + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_sched_ctrl.sv
// Directed bench for bus_rr_sched_ctrl: unicast, broadcast, fairness,
// invalid destination with saturation, POP abort and mid-packet reset.
module tb_bus_rr_sched_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] d_pop;
  logic [3:0]  pop;
  logic [15:0] d_push;
  logic [3:0]  push;
  logic        busy;
  logic [7:0]  grant_id;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  bus_rr_sched_ctrl #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
    .D_push(d_push), .push(push), .busy(busy), .grant_id(grant_id),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pop"},      32'(pop),      32'h0);
    chk({tag, "_push"},     32'(push),     32'h0);
    chk({tag, "_dpush"},    32'(d_push),   32'h0);
    chk({tag, "_busy"},     32'(busy),     32'h0);
    chk({tag, "_grant"},    32'(grant_id), 32'h0);
    chk({tag, "_pkt_cnt"},  32'(pkt_cnt),  32'h0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
  endtask

  // One packet from a single pending device; FIFO goes empty after the pop.
  task automatic xfer(input string tag, input int dev, input logic [15:0] head,
                      input logic [3:0] exp_push, input logic [15:0] exp_dpush);
    d_pop[dev*16 +: 16] = head;
    pndng = 4'(1 << dev);
    tick();
    chk({tag, "_grant"}, 32'(grant_id), 32'(dev));
    chk({tag, "_busy"},  32'(busy),     32'h1);
    chk({tag, "_pop0"},  32'(pop),      32'h0);
    tick();
    chk({tag, "_pop"},   32'(pop),      32'(1 << dev));
    pndng = 4'b0000;
    tick();
    chk({tag, "_pop_clr"}, 32'(pop),    32'h0);
    chk({tag, "_push0"},   32'(push),   32'h0);
    tick();
    chk({tag, "_push"},  32'(push),     32'(exp_push));
    chk({tag, "_dpush"}, 32'(d_push),   32'(exp_dpush));
    chk({tag, "_pop_off"}, 32'(pop),    32'h0);
  endtask

  logic [15:0] heads [4];
  logic [3:0]  dst   [4];

  initial begin
    reset = 1'b1;
    pndng = 4'b0000;
    d_pop = '0;
    tick();
    tick();
    chk_reset_outputs("rst");
    reset = 1'b0;

    // Unicast 1 -> 3
    xfer("uni", 1, 16'h03A5, 4'b1000, 16'h03A5);
    chk("uni_pkt_cnt", 32'(pkt_cnt), 32'd1);
    tick();
    chk("uni_idle_busy", 32'(busy), 32'h0);
    chk("uni_push_pulse", 32'(push), 32'h0);
    chk("uni_dpush_hold", 32'(d_push), 32'h03A5);

    // Broadcast from 2: everyone but the source
    xfer("bcast", 2, 16'hFF11, 4'b1011, 16'hFF11);
    chk("bcast_pkt_cnt", 32'(pkt_cnt), 32'd2);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_pkt_cnt", 32'(pkt_cnt), 32'd0);

    // Fairness with all devices pending
    heads[0] = 16'h0100; dst[0] = 4'b0010;
    heads[1] = 16'h0200; dst[1] = 4'b0100;
    heads[2] = 16'h0300; dst[2] = 4'b1000;
    heads[3] = 16'h0000; dst[3] = 4'b0001;
    for (int d = 0; d < 4; d++) d_pop[d*16 +: 16] = heads[d];
    pndng = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fair_grant", 32'(grant_id), 32'(k % 4));
      tick();
      chk("fair_pop", 32'(pop), 32'(1 << (k % 4)));
      tick();
      tick();
      chk("fair_push",  32'(push),   32'(dst[k % 4]));
      chk("fair_dpush", 32'(d_push), 32'(heads[k % 4]));
    end
    pndng = 4'b0000;
    chk("fair_pkt_cnt", 32'(pkt_cnt), 32'd5);

    // Invalid destination: popped but dropped
    xfer("inv", 0, 16'h0700, 4'b0000, 16'h0100);
    chk("inv_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("inv_pkt_cnt",  32'(pkt_cnt),  32'd5);

    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    xfer("sat1", 0, 16'h0700, 4'b0000, 16'h0100);
    chk("sat1_drop_cnt", 32'(drop_cnt), 32'hFFFF);
    xfer("sat2", 0, 16'h0700, 4'b0000, 16'h0100);
    chk("sat2_drop_cnt", 32'(drop_cnt), 32'hFFFF);
    chk("sat2_pkt_cnt",  32'(pkt_cnt),  32'd5);

    // Abort in POP: rr_ptr stays at 1, so 4'b0011 must grant 1 next
    d_pop[0 +: 16]  = 16'h0100;
    d_pop[16 +: 16] = 16'h0205;
    pndng = 4'b0010;
    tick();
    chk("abort_grant", 32'(grant_id), 32'd1);
    pndng = 4'b0000;
    tick();
    chk("abort_pop",  32'(pop),  32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    pndng = 4'b0011;
    tick();
    chk("abort_regrant", 32'(grant_id), 32'd1);
    tick();
    chk("abort_pop2", 32'(pop), 32'h2);

    // Reset while in ROUTE
    reset = 1'b1;
    tick();
    chk_reset_outputs("rst_route");
    reset = 1'b0;
    tick();
    chk("post_rst_push",  32'(push),     32'h0);
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    chk("post_rst_busy",  32'(busy),     32'h1);
    pndng = 4'b0000;
    tick();
    chk("post_rst_nopop", 32'(pop), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_sched_ctrl.md
Name: bus_rr_sched_ctrl

Overview:
- Round-robin scheduler/controller for the shared packet bus between `drvrs` device FIFOs.
- Scans each device's pending flag and grants one requester at a time.
- Pops the granted head packet and decodes its destination ID.
- Pushes the packet to the destination device, or to all other devices on broadcast.
- Sits between the per-device input FIFOs (pndng/pop/D_pop) and the per-device output FIFOs (push/D_push). Same FIFO-side signalling as the existing bus generator/arbiter.

Parameters:
- drvrs, 4, number of devices on the bus; legal range 2..255.
- pckg_sz, 16, packet width in bits; must be >= 9. Bits [pckg_sz-1 -: 8] carry the destination ID; the rest is payload.
- broadcast, 8'hFF, destination ID that means "deliver to every device except the source".

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pndng  in  drvrs  bit i = device i input FIFO non-empty.
- D_pop  in  drvrs*pckg_sz  head word of device i at [i*pckg_sz +: pckg_sz]. First-word-fall-through: valid whenever pndng[i]=1.
- pop  out  drvrs  one-hot, 1-cycle pulse; dequeues the head of device i.
- D_push  out  pckg_sz  packet being delivered; shared by all devices.
- push  out  drvrs  write strobe per destination device, 1-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  8  index of the current or last granted source.
- pkt_cnt  out  16  delivered-packet counter; wraps.
- drop_cnt  out  16  dropped-packet counter; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - pop=0, push=0, D_push=0, busy=0, grant_id=0, pkt_cnt=0, drop_cnt=0.
  - Internal rr_ptr=0, state=IDLE, capture register=0.
- Reset applied mid-operation takes effect at the next rising edge. Any in-flight packet is discarded: no pop or push is issued after that edge, and counters are not updated.
- All outputs are registered.
- States:
  - IDLE: if pndng != 0, select the first set bit searching upward from rr_ptr, with wrap-around modulo drvrs. Register it into grant_id and go to POP. Otherwise stay in IDLE.
  - POP:
    - If pndng[grant_id]=1: assert pop[grant_id] for this cycle only, capture D_pop slice grant_id, go to ROUTE.
    - If pndng[grant_id] has dropped: issue no pop, return to IDLE, rr_ptr unchanged.
  - ROUTE: decode dest = captured[pckg_sz-1 -: 8].
    - dest == broadcast: mask = all ones with bit grant_id cleared.
    - dest < drvrs: mask = one-hot(dest). Unicast to self is legal and is delivered.
    - Otherwise the destination is invalid: mask = 0.
    - Go to PUSH.
  - PUSH:
    - If mask != 0: drive D_push=captured and push=mask for exactly one cycle; pkt_cnt += 1.
    - If mask == 0: no push; drop_cnt += 1 (saturating).
    - rr_ptr = (grant_id+1) mod drvrs. Go to IDLE.
- Timing:
  - pndng sampled in IDLE at cycle N → pop at N+1 → push at N+3.
  - Throughput is one packet per 4 cycles.
  - D_push holds its last delivered value between pushes.
- Fairness:
  - With all devices continuously pending, grants rotate 0,1,...,drvrs-1,0,...
  - No device waits more than drvrs grants.
- Boundaries:
  - rr_ptr = drvrs-1 wraps to 0.
  - Only one device pending: that device is granted repeatedly, regardless of rr_ptr.
  - pndng toggling during ROUTE/PUSH is ignored.
  - pop and push are never asserted in the same cycle.

Test Plan:
1. Reset, then pndng=4'b0010 with D_pop[1] = 16'h03A5 → pop=4'b0010 at N+1; push=4'b1000 and D_push=16'h03A5 at N+3; pkt_cnt=1.
2. Broadcast: device 2 head = 16'hFF11 → push=4'b1011, D_push=16'hFF11; source bit 2 is not pushed.
3. Fairness: pndng=4'b1111 held, all heads valid unicast → grant_id sequence 0,1,2,3,0; four pushes in 16 cycles.
4. Invalid destination: device 0 head = 16'h0700 → pop pulses, no push, drop_cnt=1, pkt_cnt unchanged. Force drop_cnt to 16'hFFFF, drop again → stays 16'hFFFF.
5. Abort and reset:
   - Deassert pndng[grant] in the POP cycle → no pop, return to IDLE, rr_ptr unchanged.
   - Assert reset during ROUTE → no push follows, all outputs 0 next cycle, next grant starts from device 0.
